// File: rtl/key_counter_bcd_if.sv
// Key inputs and display/count outputs of key_counter_bcd, bundled into one port.
// The design drives the outputs through the slave modport; the board side or bench uses the master modport.
interface key_counter_bcd_if #(
    parameter int DIGITS = 2
);
    logic                  key_inc;
    logic                  key_dec;
    logic                  key_clr;
    logic [4*DIGITS-1:0]   count_bcd;
    logic                  wrap;
    logic [7:0]            seg;
    logic [DIGITS-1:0]     dig_sel;

    modport master (
        output key_inc, key_dec, key_clr,
        input  count_bcd, wrap, seg, dig_sel
    );

    modport slave (
        input  key_inc, key_dec, key_clr,
        output count_bcd, wrap, seg, dig_sel
    );
endinterface

// File: rtl/key_counter_bcd.sv
// Debounced inc/dec/clear key counter with a DIGITS-wide BCD count and a scanned 7-segment display.
// Each key goes through a 2-flop synchroniser and a stability counter; a release-to-press transition gives one pulse.
module key_counter_bcd #(
    parameter int DIGITS         = 2,
    parameter int DEBOUNCE_CYC   = 1_000_000,
    parameter int SCAN_CYC       = 50_000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit BLANK_LZ       = 1'b1
) (
    input  logic              clk,
    input  logic              res,
    key_counter_bcd_if.slave  bus
);
    localparam int NK     = 3;
    localparam int K_INC  = 0;
    localparam int K_DEC  = 1;
    localparam int K_CLR  = 2;
    localparam int DEB_W  = $clog2(DEBOUNCE_CYC);
    localparam int SCAN_W = $clog2(SCAN_CYC);
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW     = 4 * DIGITS;

    logic [NK-1:0]             raw;
    logic [NK-1:0]             sync0_q, sync0_d, sync1_q, sync1_d;
    logic [NK-1:0]             lvl_q, lvl_d, lvl_dly_q, lvl_dly_d;
    logic [NK-1:0]             armed_q, armed_d, press_q, press_d;
    logic [NK-1:0][DEB_W-1:0]  cnt_q, cnt_d;
    logic [1:0]                flush_q, flush_d;

    logic [CW-1:0]             count_q, count_d;
    logic                      wrap_q, wrap_d;
    logic                      carry;

    logic [SCAN_W-1:0]         scan_q, scan_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [3:0]                digit;
    logic                      upper_zero, blank;
    logic [7:0]                seg_act, seg_q, seg_d;
    logic [DIGITS-1:0]         sel_act, sel_q, sel_d;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    assign raw = {bus.key_clr, bus.key_dec, bus.key_inc};

    // A key held across reset is only armed once a genuine released level has passed the synchroniser.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        sync0_d   = raw;
        sync1_d   = sync0_q;
        flush_d   = {flush_q[0], 1'b1};
        lvl_d     = lvl_q;
        lvl_dly_d = lvl_q;
        cnt_d     = '0;
        armed_d   = armed_q | (sync1_q & {NK{flush_q[1]}});
        press_d   = armed_q & lvl_dly_q & ~lvl_q;
        for (int k = 0; k < NK; k++) begin
            if (sync1_q[k] != lvl_q[k]) begin
                if (cnt_q[k] == DEB_W'(DEBOUNCE_CYC - 1)) lvl_d[k] = sync1_q[k];
                else                                      cnt_d[k] = cnt_q[k] + 1'b1;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        carry   = 1'b1;
        if (press_q[K_CLR]) begin
            count_d = '0;
        end else if (press_q[K_INC] && !press_q[K_DEC]) begin
            for (int d = 0; d < DIGITS; d++) begin
                if (carry) begin
                    if (count_q[4*d +: 4] == 4'd9) begin
                        count_d[4*d +: 4] = 4'd0;
                    end else begin
                        count_d[4*d +: 4] = count_q[4*d +: 4] + 4'd1;
                        carry = 1'b0;
                    end
                end
            end
            wrap_d = carry;
        end else if (press_q[K_DEC] && !press_q[K_INC]) begin
            for (int d = 0; d < DIGITS; d++) begin
                if (carry) begin
                    if (count_q[4*d +: 4] == 4'd0) begin
                        count_d[4*d +: 4] = 4'd9;
                    end else begin
                        count_d[4*d +: 4] = count_q[4*d +: 4] - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
            wrap_d = carry;
        end
    end

    always_comb begin
        scan_d = scan_q + 1'b1;
        idx_d  = idx_q;
        if (scan_q == SCAN_W'(SCAN_CYC - 1)) begin
            scan_d = '0;
            idx_d  = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        digit      = count_q[4*int'(idx_q) +: 4];
        upper_zero = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (d >= int'(idx_q) && count_q[4*d +: 4] != 4'd0) upper_zero = 1'b0;
        end
        blank          = BLANK_LZ && (idx_q != '0) && upper_zero;
        seg_act        = blank ? 8'h00 : {1'b0, seg7(digit)};
        sel_act        = '0;
        sel_act[idx_q] = 1'b1;
        seg_d          = SEG_ACTIVE_LOW ? ~seg_act : seg_act;
        sel_d          = SEG_ACTIVE_LOW ? ~sel_act : sel_act;
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!res) begin
            sync0_q   <= '1;
            sync1_q   <= '1;
            lvl_q     <= '1;
            lvl_dly_q <= '1;
            armed_q   <= '0;
            press_q   <= '0;
            cnt_q     <= '0;
            flush_q   <= '0;
            count_q   <= '0;
            wrap_q    <= 1'b0;
            scan_q    <= '0;
            idx_q     <= '0;
            seg_q     <= {8{SEG_ACTIVE_LOW}};
            sel_q     <= {DIGITS{SEG_ACTIVE_LOW}};
        end else begin
            sync0_q   <= sync0_d;
            sync1_q   <= sync1_d;
            lvl_q     <= lvl_d;
            lvl_dly_q <= lvl_dly_d;
            armed_q   <= armed_d;
            press_q   <= press_d;
            cnt_q     <= cnt_d;
            flush_q   <= flush_d;
            count_q   <= count_d;
            wrap_q    <= wrap_d;
            scan_q    <= scan_d;
            idx_q     <= idx_d;
            seg_q     <= seg_d;
            sel_q     <= sel_d;
        end
    end

    assign bus.count_bcd = count_q;
    assign bus.wrap      = wrap_q;
    assign bus.seg       = seg_q;
    assign bus.dig_sel   = sel_q;
endmodule

// File: doc/key_counter_bcd.md
# key_counter_bcd

Parametrised successor to the single-key press counter. It counts debounced presses on separate increment, decrement and clear keys into a DIGITS-wide BCD counter, and drives a time-multiplexed 7-segment display with one-hot digit select. It sits between the raw board push-buttons and the segment/anode pins, and debouncing is integrated per key.

## Interface
- DIGITS, 2: number of BCD digits and display positions (1..8).
- DEBOUNCE_CYC, 1_000_000: clk cycles a synchronised key level must stay stable before it is accepted (≥2).
- SCAN_CYC, 50_000: clk cycles each digit stays selected (≥2).
- SEG_ACTIVE_LOW, 1: 1 means seg and dig_sel are active-low; 0 means active-high.
- BLANK_LZ, 1: 1 means leading zeros are blanked; the least-significant digit is always shown.

- clk  in  1  system clock; all logic on rising edge.
- res  in  1  synchronous, active-low reset.
- key_inc  in  1  raw increment button, pressed = 0, asynchronous.
- key_dec  in  1  raw decrement button, pressed = 0, asynchronous.
- key_clr  in  1  raw clear button, pressed = 0, asynchronous.
- count_bcd  out  4*DIGITS  current count; digit k occupies [4k+3:4k].
- wrap  out  1  one-cycle pulse on a 9..9→0..0 or 0..0→9..9 wrap.
- seg  out  8  {dp,g,f,e,d,c,b,a} for the selected digit; dp is always off.
- dig_sel  out  DIGITS  one-hot digit enable; bit 0 is the least-significant digit.

## Operation
- **Reset (res=0 at an edge):**
  - count_bcd=0 and wrap=0.
  - All sync and debounce state is set to released (1), and debounce counters are 0.
  - Scan index = 0 and scan counter = 0.
  - seg and dig_sel are driven inactive: all 1s if SEG_ACTIVE_LOW, else all 0s.
- **Per-key front end (three identical instances):**
  - 2-flop synchroniser, then a stable-level register `lvl` (reset 1) and a counter `cnt`.
  - While sync ≠ lvl, `cnt` increments.
  - When sync ≠ lvl and `cnt` = DEBOUNCE_CYC-1, `lvl` takes the sync value and `cnt` clears.
  - Whenever sync = lvl, `cnt` clears.
  - A press pulse is asserted for one cycle on the edge after `lvl` goes 1→0. Release generates nothing. Holding a key gives exactly one pulse.
- **Counter update, registered on the cycle of the press pulse, in priority order:**
  - clr pulse: count set to 0. clr beats inc/dec; no wrap.
  - inc and dec pulses in the same cycle: no change.
  - inc: BCD add 1 with per-digit carry (digit 9 goes to 0 and carries). If all digits were 9, the result is all 0 and wrap=1.
  - dec: BCD subtract 1 with per-digit borrow (digit 0 goes to 9 and borrows). If all digits were 0, the result is all 9s and wrap=1.
  - wrap is high only for the cycle after the wrapping update.
- **Display scan:**
  - The scan counter counts 0..SCAN_CYC-1. At terminal count, the scan index advances (DIGITS-1 wraps to 0).
  - dig_sel asserts bit[index] only.
  - seg shows the 7-segment decode of digit[index], using standard hex 0–9 patterns (0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F in active-high {g..a}), inverted if SEG_ACTIVE_LOW.
  - Blanking: when BLANK_LZ=1 and index>0, a digit is blanked (seg all inactive, dig_sel still asserted) if it and all more-significant digits are 0.
  - seg and dig_sel are registered outputs.
- Illegal BCD nibbles cannot occur; no recovery logic is required.

## Timing
- Raw key low is first sampled at edge E0. The sync output is low after E1. `lvl` falls at E1+DEBOUNCE_CYC. The press pulse is high the following cycle. count_bcd changes one cycle after that, at E0+DEBOUNCE_CYC+3.
- A glitch shorter than DEBOUNCE_CYC synchronised cycles produces no pulse.
- Scan:
  - First exit from reset: index 0 with registered seg/dig_sel valid one cycle after res deasserts.
  - Each digit is held for SCAN_CYC cycles.
  - Full frame = DIGITS*SCAN_CYC cycles.
- A count change is visible on seg at the next edge if its digit is currently selected.
- Reset mid-debounce or mid-scan aborts everything: no pulse is emitted for a key held across reset until it is released and pressed again.

## Test plan
All scenarios use DIGITS=2, DEBOUNCE_CYC=4, SCAN_CYC=3, SEG_ACTIVE_LOW=1, BLANK_LZ=1.
1. Reset, then hold key_inc low for 20 cycles → exactly one increment; count_bcd=8'h01 at E0+7; wrap=0; releasing gives no change.
2. Bounce key_inc low for 3 cycles, high for 2, repeatedly for 40 cycles → count stays 8'h00.
3. Preload via 99 inc presses to 8'h99, then one inc → 8'h00 with a 1-cycle wrap; then one dec → 8'h99 with a 1-cycle wrap.
4. Force inc and dec pulses in the same cycle at count 8'h42 → stays 8'h42. Force clr+inc in the same cycle → 8'h00 with no wrap.
5. Scan at count 8'h07 → dig_sel alternates 2'b10 (digit0) and 2'b01 (digit1), 3 cycles each. seg=8'hF8 on digit 0 and 8'hFF (blanked) on digit 1. At count 8'h10, digit 1 shows 8'hF9 and digit 0 shows 8'hC0.
6. Assert res low for 1 cycle mid-count (8'h35) while key_dec is held → count 8'h00, seg/dig_sel all 1s during reset, and no decrement until key_dec is released and re-pressed.
